// File: rtl/hub75_scan_driver.sv
// HUB75 scan engine: walks col/row into the pixel generator and serialises its RGB bits onto the panel.
// Latency: panel data is registered one cycle after sampling; row period is 2*COLS + 2 + ON_CYCLES cycles.
// No backpressure: en is sampled only in IDLE and at the end of DISPLAY, so a started row always completes.
module hub75_scan_driver #(
  parameter int COLS      = 64,
  parameter int ROWS      = 16,
  parameter int ADDR_W    = 4,
  parameter int COL_W     = 6,
  parameter int ON_CYCLES = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [COL_W-1:0]  pix_col,
  output logic [ADDR_W-1:0] pix_row,
  input  logic              r0,
  input  logic              g0,
  input  logic              b0,
  input  logic              r1,
  input  logic              g1,
  input  logic              b1,
  output logic              panel_r0,
  output logic              panel_g0,
  output logic              panel_b0,
  output logic              panel_r1,
  output logic              panel_g1,
  output logic              panel_b1,
  output logic              panel_clk,
  output logic              panel_lat,
  output logic              panel_oe_n,
  output logic [ADDR_W-1:0] panel_addr,
  output logic              frame_done
);

  localparam int DW = (ON_CYCLES > 1) ? $clog2(ON_CYCLES) : 1;
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROWS - 1);
  localparam logic [DW-1:0]     ON_LAST  = DW'(ON_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY} state_t;

  state_t              state, state_nxt;
  logic [COL_W-1:0]    col, col_nxt;
  logic [ADDR_W-1:0]   row, row_nxt;
  logic                phase, phase_nxt;   // 0 = phase A (capture data), 1 = phase B (raise clock)
  logic [DW-1:0]       dcnt, dcnt_nxt;
  logic [5:0]          data, data_nxt;     // {r0, g0, b0, r1, g1, b1}
  logic                pclk, pclk_nxt;
  logic                lat, lat_nxt;
  logic                oe_n, oe_n_nxt;
  logic [ADDR_W-1:0]   addr, addr_nxt;
  logic                fdone, fdone_nxt;

  // Next-state and next-output logic; every register holds unless a state overrides it.
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    phase_nxt = phase;
    dcnt_nxt  = dcnt;
    data_nxt  = data;
    pclk_nxt  = pclk;
    lat_nxt   = lat;
    oe_n_nxt  = oe_n;
    addr_nxt  = addr;
    fdone_nxt = 1'b0;
    case (state)
      IDLE: begin
        pclk_nxt  = 1'b0;
        lat_nxt   = 1'b0;
        oe_n_nxt  = 1'b1;
        col_nxt   = '0;
        phase_nxt = 1'b0;
        if (en) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (!phase) begin
          // Data changes only together with the falling shift clock.
          data_nxt  = {r0, g0, b0, r1, g1, b1};
          pclk_nxt  = 1'b0;
          phase_nxt = 1'b1;
        end else begin
          pclk_nxt  = 1'b1;
          phase_nxt = 1'b0;
          if (col == COL_LAST) begin
            col_nxt   = '0;
            state_nxt = BLANK;
          end else begin
            col_nxt = col + 1'b1;
          end
        end
      end
      BLANK: begin
        // Address moves while the panel is dark; latch goes high once the clock is low.
        pclk_nxt  = 1'b0;
        oe_n_nxt  = 1'b1;
        addr_nxt  = row;
        lat_nxt   = 1'b1;
        state_nxt = LATCH;
      end
      LATCH: begin
        lat_nxt   = 1'b0;
        oe_n_nxt  = 1'b0;
        dcnt_nxt  = '0;
        state_nxt = DISPLAY;
      end
      DISPLAY: begin
        if (dcnt == ON_LAST) begin
          oe_n_nxt = 1'b1;
          dcnt_nxt = '0;
          if (row == ROW_LAST) begin
            row_nxt   = '0;
            fdone_nxt = 1'b1;
          end else begin
            row_nxt = row + 1'b1;
          end
          state_nxt = en ? SHIFT : IDLE;
        end else begin
          dcnt_nxt = dcnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        oe_n_nxt  = 1'b1;
      end
    endcase
  end

  // State and output registers; reset forces the panel dark with no latch pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
      phase <= 1'b0;
      dcnt  <= '0;
      data  <= '0;
      pclk  <= 1'b0;
      lat   <= 1'b0;
      oe_n  <= 1'b1;
      addr  <= '0;
      fdone <= 1'b0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
      phase <= phase_nxt;
      dcnt  <= dcnt_nxt;
      data  <= data_nxt;
      pclk  <= pclk_nxt;
      lat   <= lat_nxt;
      oe_n  <= oe_n_nxt;
      addr  <= addr_nxt;
      fdone <= fdone_nxt;
    end
  end

  assign pix_col    = col;
  assign pix_row    = row;
  assign panel_r0   = data[5];
  assign panel_g0   = data[4];
  assign panel_b0   = data[3];
  assign panel_r1   = data[2];
  assign panel_g1   = data[1];
  assign panel_b1   = data[0];
  assign panel_clk  = pclk;
  assign panel_lat  = lat;
  assign panel_oe_n = oe_n;
  assign panel_addr = addr;
  assign frame_done = fdone;

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Directed bench for hub75_scan_driver with a small 4x2 panel and 3 on-cycles.
// Samples 1 time unit after each rising edge; invariants are watched on the falling edge.
// No backpressure on the DUT; all loops run for fixed cycle counts.
module tb_hub75_scan_driver;
  localparam int COLS = 4, ROWS = 2, ADDR_W = 2, COL_W = 2, ON = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic [COL_W-1:0]  pix_col;
  logic [ADDR_W-1:0] pix_row;
  logic r0, g0, b0, r1, g1, b1;
  logic panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1;
  logic panel_clk, panel_lat, panel_oe_n, frame_done;
  logic [ADDR_W-1:0] panel_addr;

  int nvec = 0;
  int nerr = 0;

  // Generator model: upper red follows column parity, lower blue follows row parity.
  assign r0 = pix_col[0];
  assign g0 = pix_col[1];
  assign b0 = 1'b0;
  assign r1 = 1'b0;
  assign g1 = 1'b0;
  assign b1 = pix_row[0];

  always #5 clk = ~clk;

  hub75_scan_driver #(
    .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .COL_W(COL_W), .ON_CYCLES(ON)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .pix_col(pix_col), .pix_row(pix_row),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .panel_r0(panel_r0), .panel_g0(panel_g0), .panel_b0(panel_b0),
    .panel_r1(panel_r1), .panel_g1(panel_g1), .panel_b1(panel_b1),
    .panel_clk(panel_clk), .panel_lat(panel_lat), .panel_oe_n(panel_oe_n),
    .panel_addr(panel_addr), .frame_done(frame_done)
  );

  task automatic check(input string tag, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Per-cycle capture of DUT outputs, indexed from the first SHIFT cycle.
  logic              a_oe  [64];
  logic              a_lat [64];
  logic              a_clk [64];
  logic              a_fd  [64];
  logic              a_r0  [64];
  logic              a_b1  [64];
  logic [ADDR_W-1:0] a_addr[64];
  logic [ADDR_W-1:0] a_prow[64];
  logic [COL_W-1:0]  a_pcol[64];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rec(input int k);
    a_oe[k]   = panel_oe_n;
    a_lat[k]  = panel_lat;
    a_clk[k]  = panel_clk;
    a_fd[k]   = frame_done;
    a_r0[k]   = panel_r0;
    a_b1[k]   = panel_b1;
    a_addr[k] = panel_addr;
    a_prow[k] = pix_row;
    a_pcol[k] = pix_col;
  endtask

  function automatic int rises(input int a, input int b);
    int n = 0;
    for (int k = a; k <= b; k++) if (a_clk[k] && !a_clk[k-1]) n++;
    return n;
  endfunction

  function automatic int low_oe(input int a, input int b);
    int n = 0;
    for (int k = a; k <= b; k++) if (!a_oe[k]) n++;
    return n;
  endfunction

  function automatic int hi_lat(input int a, input int b);
    int n = 0;
    for (int k = a; k <= b; k++) if (a_lat[k]) n++;
    return n;
  endfunction

  function automatic int hi_fd(input int a, input int b);
    int n = 0;
    for (int k = a; k <= b; k++) if (a_fd[k]) n++;
    return n;
  endfunction

  // Invariant monitor on the falling edge.
  logic [ADDR_W-1:0] prev_addr = '0;
  logic              prev_oe_n = 1'b1;
  logic              prev_fd   = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      check("inv_lat_oe",    int'(panel_lat & ~panel_oe_n), 0);
      check("inv_clk_lat",   int'(panel_clk & panel_lat), 0);
      check("inv_addr_hold", int'(!panel_oe_n && !prev_oe_n && (panel_addr != prev_addr)), 0);
      check("inv_fd_width",  int'(frame_done & prev_fd), 0);
    end
    prev_addr = panel_addr;
    prev_oe_n = panel_oe_n;
    prev_fd   = frame_done;
  end

  initial begin
    // Reset values.
    rst = 1'b1;
    en  = 1'b0;
    step();
    step();
    check("rst_oe_n",  int'(panel_oe_n), 1);
    check("rst_lat",   int'(panel_lat), 0);
    check("rst_clk",   int'(panel_clk), 0);
    check("rst_addr",  int'(panel_addr), 0);
    check("rst_fd",    int'(frame_done), 0);
    check("rst_col",   int'(pix_col), 0);
    check("rst_row",   int'(pix_row), 0);

    // Two full frames with en held high.
    rst = 1'b0;
    en  = 1'b1;
    for (int k = 0; k <= 52; k++) begin
      step();
      rec(k);
    end
    check("row0_clk_rises", rises(1, 12), 4);
    check("row1_clk_rises", rises(13, 25), 4);
    check("row0_lat_cycles", hi_lat(0, 12), 1);
    check("row0_lat_at9", int'(a_lat[9]), 1);
    check("row0_oe_low", low_oe(0, 12), 3);
    check("row0_oe_at10", int'(a_oe[10]), 0);
    check("row1_oe_at13", int'(a_oe[13]), 1);
    check("row1_oe_low", low_oe(13, 25), 3);
    check("row1_oe_at23", int'(a_oe[23]), 0);
    check("addr_row0", int'(a_addr[10]), 0);
    check("addr_row1", int'(a_addr[23]), 1);
    check("addr_row2", int'(a_addr[36]), 0);

    // Row 1 serial data at each shift-clock rise (cycles 15,17,19,21).
    check("row1_prow", int'(a_prow[13]), 1);
    check("row1_pcol15", int'(a_pcol[15]), 1);
    for (int c = 0; c < COLS; c++) begin
      check("row1_clk_hi", int'(a_clk[15 + 2*c]), 1);
      check("row1_r0", int'(a_r0[15 + 2*c]), c % 2);
      check("row1_b1", int'(a_b1[15 + 2*c]), 1);
    end

    // Frame-done pulses.
    check("fd_at26", int'(a_fd[26]), 1);
    check("fd_at52", int'(a_fd[52]), 1);
    check("fd_count", hi_fd(0, 52), 2);

    // en dropped during row 0 shift: row completes, then idle.
    rst = 1'b1;
    step();
    rst = 1'b0;
    en  = 1'b1;
    for (int k = 0; k <= 19; k++) begin
      step();
      rec(k);
      if (k == 3) en = 1'b0;
    end
    check("drop_lat_at9", int'(a_lat[9]), 1);
    check("drop_oe_low", low_oe(0, 19), 3);
    check("drop_oe_at12", int'(a_oe[12]), 0);
    check("drop_oe_at13", int'(a_oe[13]), 1);
    check("drop_idle_rises", rises(13, 19), 0);
    check("drop_prow", int'(a_prow[19]), 1);
    check("drop_pcol", int'(a_pcol[19]), 0);

    // Re-assert en: scanning resumes at row 1.
    en = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      step();
      rec(k);
    end
    check("resume_prow", int'(a_prow[0]), 1);
    check("resume_b1", int'(a_b1[2]), 1);
    check("resume_addr", int'(a_addr[10]), 1);
    check("resume_oe_at10", int'(a_oe[10]), 0);

    // Reset during DISPLAY takes effect immediately.
    rst = 1'b1;
    #1;
    check("mid_rst_oe_n", int'(panel_oe_n), 1);
    check("mid_rst_lat", int'(panel_lat), 0);
    check("mid_rst_addr", int'(panel_addr), 0);
    check("mid_rst_fd", int'(frame_done), 0);
    check("mid_rst_row", int'(pix_row), 0);
    step();
    rst = 1'b0;
    en  = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      step();
      rec(k);
    end
    check("restart_prow", int'(a_prow[0]), 0);
    check("restart_b1", int'(a_b1[2]), 0);
    check("restart_lat", int'(a_lat[9]), 1);
    check("restart_addr", int'(a_addr[10]), 0);
    check("restart_oe_low", low_oe(0, 12), 3);

    // Random en for 1000 cycles; the falling-edge monitor checks invariants.
    for (int i = 0; i < 1000; i++) begin
      if (i % 7 == 0) en = 1'($urandom_range(0, 1));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
